alu_mul_seq: RTL and testbench

Multi-cycle sequencer that borrows the shared 16-bit ALU (zx/nx/zy/ny/f/no control) for multiply and left-shift. These are operations the ALU cannot do in one pass. It requests the ALU through a req/gnt handshake, drives X, Y and C each step, and captures the combinational result on each clock edge. It sits beside the CPU datapath; the owner of the ALU muxes in alu_x/alu_y/alu_c while alu_gnt=1.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_seq.sv | 148 ++++++++++++++
 tb/tb_alu_mul_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared control encodings for the 16-bit zx/nx/zy/ny/f/no ALU and its multi-cycle sequencer.
package alu_pkg;

    localparam logic [5:0] ALU_ADD    = 6'b000010;
    localparam logic [5:0] ALU_ZERO   = 6'b101010;
    localparam logic [5:0] ALU_PASS_Y = 6'b110000;
    localparam logic [5:0] ALU_AND    = 6'b000000;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_SHL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ADD,
        DBL,
        SHF,
        FIN
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply / repeated-double shift-left built on the shared ALU.
// One ALU pass per granted cycle; a dropped alu_gnt freezes the step in place.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_c,
    input  logic [WIDTH-1:0] alu_out
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_ar;
    logic [WIDTH-1:0] r_br;
    logic [WIDTH-1:0] r_result;
    logic             r_op;
    logic             r_done;

    assign ready  = (r_state == IDLE);
    assign done   = r_done;
    assign result = r_result;

    always_comb begin
        w_next  = r_state;
        alu_req = 1'b0;
        alu_x   = '0;
        alu_y   = '0;
        alu_c   = ALU_ZERO;
        case (r_state)
            IDLE: begin
                if (start) w_next = WAIT;
            end
            WAIT: begin
                alu_req = 1'b1;
                if (alu_gnt) begin
                    if (r_br == '0)          w_next = FIN;
                    else if (r_op == OP_SHL) w_next = SHF;
                    else if (r_br[0])        w_next = ADD;
                    else                     w_next = DBL;
                end
            end
            ADD: begin
                alu_req = 1'b1;
                alu_x   = r_acc;
                alu_y   = r_ar;
                alu_c   = ALU_ADD;
                if (alu_gnt) w_next = DBL;
            end
            DBL: begin
                // Next decision looks at br after this step's shift: bit1 becomes the new bit0.
                alu_req = 1'b1;
                alu_x   = r_ar;
                alu_y   = r_ar;
                alu_c   = ALU_ADD;
                if (alu_gnt) begin
                    if (r_br[WIDTH-1:1] == '0) w_next = FIN;
                    else if (r_br[1])          w_next = ADD;
                    else                       w_next = DBL;
                end
            end
            SHF: begin
                alu_req = 1'b1;
                alu_x   = r_acc;
                alu_y   = r_acc;
                alu_c   = ALU_ADD;
                if (alu_gnt) begin
                    if (r_br == ONE) w_next = FIN;
                    else             w_next = SHF;
                end
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_ar     <= '0;
            r_br     <= '0;
            r_op     <= OP_MUL;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_ar <= a;
                        if (op == OP_SHL) begin
                            r_acc <= a;
                            r_br  <= {{(WIDTH-CNT_W){1'b0}}, b[CNT_W-1:0]};
                        end else begin
                            r_acc <= '0;
                            r_br  <= b;
                        end
                    end
                end
                ADD: begin
                    if (alu_gnt) r_acc <= alu_out;
                end
                DBL: begin
                    if (alu_gnt) begin
                        r_ar <= alu_out;
                        r_br <= r_br >> 1;
                    end
                end
                SHF: begin
                    if (alu_gnt) begin
                        r_acc <= alu_out;
                        r_br  <= r_br - ONE;
                    end
                end
                FIN: begin
                    r_result <= r_acc;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomised bench for alu_mul_seq with a behavioural ALU and an arithmetic reference model.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        alu_req;
    logic        alu_gnt = 1'b1;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_c;
    logic [15:0] alu_out;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] prev_res = '0;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign alu_out = alu_ref(alu_x, alu_y, alu_c);

    alu_mul_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .done(done), .result(result),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_x(alu_x), .alu_y(alu_y),
        .alu_c(alu_c), .alu_out(alu_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_latency(input logic op_i, input logic [15:0] b_i);
        int msb;
        if (op_i) return 2 + int'(b_i[3:0]);
        if (b_i == 16'h0) return 2;
        msb = 0;
        for (int i = 0; i < 16; i++) if (b_i[i]) msb = i;
        return 2 + $countones(b_i) + msb + 1;
    endfunction

    function automatic logic [15:0] ref_result(input logic op_i, input logic [15:0] a_i,
                                               input logic [15:0] b_i);
        logic [31:0] p;
        if (op_i) return a_i << b_i[3:0];
        p = a_i * b_i;
        return p[15:0];
    endfunction

    // mode 0: gnt always 1; mode 1: random gnt; mode 2: gnt low on cycles 4..6 after accept.
    task automatic run_op(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                          input int mode, input bit busy_start);
        int          need, consumed;
        bit          fin, ok;
        logic [15:0] exp;
        need = ref_latency(op_i, b_i) - 1;
        exp  = ref_result(op_i, a_i, b_i);
        @(negedge clk);
        chk("idle_ready", ready, 1);
        chk("idle_done", done, 0);
        chk("held_result", result, prev_res);
        chk("idle_req", alu_req, 0);
        chk("idle_c", alu_c, 6'b101010);
        chk("idle_x", alu_x, 0);
        start = 1'b1; op = op_i; a = a_i; b = b_i; alu_gnt = 1'b1;
        consumed = 0; fin = 0; ok = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = (busy_start && c == 2);
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
            if (consumed < need) begin
                chk("busy_req", alu_req, 1);
                chk("busy_ready", ready, 0);
                chk("busy_done", done, 0);
                chk("busy_c", alu_c, (consumed == 0) ? 6'b101010 : 6'b000010);
                case (mode)
                    1:       alu_gnt = ($urandom_range(0, 3) != 0);
                    2:       alu_gnt = !(c >= 4 && c <= 6);
                    default: alu_gnt = 1'b1;
                endcase
                if (alu_gnt) consumed++;
            end else if (!fin) begin
                chk("fin_req", alu_req, 0);
                chk("fin_done", done, 0);
                chk("fin_c", alu_c, 6'b101010);
                alu_gnt = 1'($urandom);
                fin = 1;
            end else begin
                chk("done_pulse", done, 1);
                chk("result", result, exp);
                chk("done_ready", ready, 1);
                ok = 1;
                break;
            end
        end
        start = 1'b0;
        if (!ok) chk("done_timeout", 0, 1);
        prev_res = exp;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_req", alu_req, 0);
        chk("rst_x", alu_x, 0);
        chk("rst_y", alu_y, 0);
        chk("rst_c", alu_c, 6'b101010);
        reset = 1'b0;

        run_op(1'b0, 16'd3, 16'd5, 0, 0);
        run_op(1'b0, 16'h1234, 16'h0000, 0, 0);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 0, 0);
        run_op(1'b1, 16'h0003, 16'd4, 0, 0);
        run_op(1'b1, 16'h8001, 16'd1, 0, 0);
        run_op(1'b1, 16'hABCD, 16'h0010, 0, 0);
        run_op(1'b0, 16'd7, 16'd6, 2, 1);

        // Reset in the middle of a multiply: nothing may survive it.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h0055; b = 16'h000F; alu_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_req", alu_req, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_no_done", done, 0);
        end
        prev_res = '0;
        run_op(1'b0, 16'd2, 16'd2, 0, 0);

        for (int i = 0; i < 30; i++)
            run_op(1'($urandom), 16'($urandom), 16'($urandom), (i % 2), ($urandom_range(0, 1) == 1));

        @(negedge clk);
        chk("final_done_low", done, 0);
        chk("final_result", result, prev_res);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
